mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Select sequencer and sampler that sits directly upstream of the 4-to-1 gate-level multiplexer. It drives the mux select pair to step through an enabled subset of the four inputs, waits a programmable settle time on each, and samples the mux output `f`. The collected bits are presented as one 4-bit frame over a valid/ready handshake, so one start command produces one parallel snapshot of the selected inputs.

## Interface

Parameters:
- `DWELL`, default 2: cycles each channel is held before sampling; legal range 1..15.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  scan request; sampled only in IDLE, or in PRESENT on the handshake cycle.
- `en_mask`  input  4  channel enable, bit n = input in; latched when `start` is accepted.
- `f`  input  1  mux output.
- `sel1`  output  1  mux select bit, registered.
- `sel0`  output  1  mux select bit, registered.
- `busy`  output  1  high in SETTLE.
- `frame`  output  4  sampled bits; bit n = value of `f` while channel n was selected; disabled channels read 0.
- `frame_valid`  output  1  frame available.
- `frame_ready`  input  1  consumer accepts the frame.

## Operation

- Select encoding is fixed by the mux gate equations. Channel n drives `sel1` = n[0] and `sel0` = n[1]:
  - ch0 = 0/0
  - ch1 = 1/0
  - ch2 = 0/1
  - ch3 = 1/1
- States: IDLE, SETTLE, PRESENT.
- IDLE:
  - `sel1`/`sel0` = 0/0, `busy` = 0, `frame_valid` = 0.
  - `start` with `en_mask` ≠ 0: latch the mask, clear the shadow register, set chan = lowest set bit, drive the select for chan, load dwell counter = DWELL-1, go to SETTLE.
  - `start` with `en_mask` = 0: ignored, stay in IDLE.
- SETTLE:
  - While counter ≠ 0, decrement.
  - When counter = 0, write `f` into shadow[chan].
  - If a higher enabled channel exists: chan = next higher set bit, update the select, reload counter = DWELL-1.
  - Otherwise: `frame` <= shadow with this sample merged in, go to PRESENT.
  - `start` and `en_mask` changes are ignored in SETTLE.
- PRESENT:
  - `frame_valid` = 1; `frame` is held stable; select returns to 0/0.
  - On `frame_valid` & `frame_ready`: if `start` is high with a nonzero mask in the same cycle, begin a new scan directly into SETTLE, exactly as from IDLE. Otherwise go to IDLE.
  - `frame` keeps its last value after the handshake until the next frame is loaded.
- Counter is 4 bits wide. Channel index is 2 bits and never wraps; the scan ends after the highest enabled bit.

## Timing

- Reset values: `sel1` = 0, `sel0` = 0, `busy` = 0, `frame` = 0000, `frame_valid` = 0, state IDLE.
- Asserting `rst_n` low mid-scan or mid-present forces all outputs to their reset values immediately (asynchronous). Any partial frame is discarded.
- Start accepted at edge 0:
  - Select for the first channel is valid after edge 0.
  - Each channel is held for exactly DWELL cycles.
  - Each channel is sampled at the edge that ends its dwell.
- With k enabled channels, `frame_valid` rises after edge k·DWELL.
- For the full mask and DWELL=2: samples at edges 2, 4, 6, 8, and `frame_valid` is high from edge 8.
- `busy` is high from edge 0 until edge k·DWELL.
- Back-to-back scans have zero idle cycles when `start` coincides with the handshake.
- `frame_ready` held low keeps PRESENT indefinitely; no frame is lost or overwritten.

## Structure

- Shared package `mux_scan_pkg`:
  - state encoding constants IDLE/SETTLE/PRESENT
  - channel-to-select mapping function (`chan` → {`sel1`, `sel0`})
  - `DWELL_MAX` = 15
- Sub-module `next_chan_find`: combinational function of the latched mask and current chan. It returns the next higher set bit and a found flag. The same logic, with chan = -1, provides the lowest set bit at start.
- The top-level test harness instantiates `mux_scan_ctrl` driving the existing `mux4x1`, with `i0`..`i3` from the bench.

## Test plan

- Full scan, inputs i3..i0 = 1010, mask 1111, DWELL=2, `frame_ready`=1 → select sequence 0/0, 1/0, 0/1, 1/1; `frame` = 1010, `frame_valid` high for 1 cycle after edge 8.
- Sparse mask 0101, inputs 1111, DWELL=3 → only ch0 then ch2 selected; `frame` = 0101 after edge 6.
- Backpressure: `frame_ready`=0 for 10 cycles after `frame_valid` → `frame` stable, `start` ignored, a new `start` pulsed during SETTLE has no effect; the handshake then returns to IDLE.
- Back-to-back: `start` high on the handshake cycle with mask 0010 → next scan begins without an IDLE cycle; `frame` = `i1` value after DWELL cycles.
- `start` with mask 0000 → stays IDLE, `busy` = 0, no `frame_valid`.
- Reset pulse low at mid-dwell of ch1 → all outputs 0 immediately, state IDLE; a subsequent scan completes with correct data.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux select sequencer: state encoding, limits and
// the channel-to-select mapping imposed by the downstream mux gate equations.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam int DWELL_MAX = 15;

    // Returns {sel1, sel0}; the mux wires sel1 to the low channel bit.
    function automatic logic [1:0] chan_sel(input logic [1:0] chan);
        return {chan[0], chan[1]};
    endfunction

endpackage

// File: rtl/next_chan_find.sv
// Finds the next enabled channel strictly above chan, or the lowest enabled
// channel when from_start is set (the "chan = -1" case).
module next_chan_find (
    input  logic [3:0] mask,
    input  logic [1:0] chan,
    input  logic       from_start,
    output logic [1:0] next_chan,
    output logic       found
);

    always_comb begin
        next_chan = 2'd0;
        found     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && mask[i] && (from_start || 2'(i) > chan)) begin
                next_chan = 2'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4-to-1 mux select through the enabled channels, dwells DWELL cycles
// on each, samples f, and presents the collected bits as one frame.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] en_mask,
    input  logic       f,
    output logic       sel1,
    output logic       sel0,
    output logic       busy,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready
);

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL - 1);

    state_t     state, state_nxt;
    logic [3:0] mask;
    logic [3:0] shadow;
    logic [3:0] merged;
    logic [1:0] chan;
    logic [3:0] cnt;
    logic [1:0] nxt_chan, first_chan;
    logic       nxt_found, first_found;
    logic       accept_start, sample, last_sample;

    next_chan_find u_next (
        .mask       (mask),
        .chan       (chan),
        .from_start (1'b0),
        .next_chan  (nxt_chan),
        .found      (nxt_found)
    );

    next_chan_find u_first (
        .mask       (en_mask),
        .chan       (2'd0),
        .from_start (1'b1),
        .next_chan  (first_chan),
        .found      (first_found)
    );

    // Handshake: frame transfers on a cycle where frame_valid & frame_ready.
    // A start on that same cycle chains straight into the next scan.
    always_comb begin
        accept_start = start && first_found &&
                       (state == IDLE || (state == PRESENT && frame_ready));
        sample       = (state == SETTLE) && (cnt == 4'd0);
        last_sample  = sample && !nxt_found;
        merged       = shadow;
        merged[chan] = f;
        busy         = (state == SETTLE);
        frame_valid  = (state == PRESENT);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_start) state_nxt = SETTLE;
            SETTLE:  if (last_sample) state_nxt = PRESENT;
            PRESENT: if (frame_ready) state_nxt = accept_start ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel1   <= 1'b0;
            sel0   <= 1'b0;
            frame  <= 4'd0;
            mask   <= 4'd0;
            shadow <= 4'd0;
            chan   <= 2'd0;
            cnt    <= 4'd0;
        end else if (accept_start) begin
            mask         <= en_mask;
            shadow       <= 4'd0;
            chan         <= first_chan;
            {sel1, sel0} <= chan_sel(first_chan);
            cnt          <= DWELL_LOAD;
        end else if (state == SETTLE) begin
            if (!sample) begin
                cnt <= cnt - 4'd1;
            end else begin
                shadow[chan] <= f;
                if (nxt_found) begin
                    chan         <= nxt_chan;
                    {sel1, sel0} <= chan_sel(nxt_chan);
                    cnt          <= DWELL_LOAD;
                end else begin
                    frame        <= merged;
                    {sel1, sel0} <= 2'b00;
                end
            end
        end
    end

endmodule
